// File: rtl/router_in_port_gen2_if.sv
// Source byte stream and per-destination FIFO write bus of the router input port.
interface router_in_port_gen2_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 4
);
    logic                 valid;
    logic [DATA_W-1:0]    data;
    logic                 last;
    logic                 ready;
    logic [NUM_PORTS-1:0] fifo_afull;
    logic [NUM_PORTS-1:0] fifo_wr_en;
    logic [DATA_W-1:0]    fifo_data;
    logic                 fifo_last;
    logic                 fifo_err;

    modport master (output valid, data, last, fifo_afull,
                    input  ready, fifo_wr_en, fifo_data, fifo_last, fifo_err);
    modport slave  (input  valid, data, last, fifo_afull,
                    output ready, fifo_wr_en, fifo_data, fifo_last, fifo_err);
endinterface

// File: rtl/router_in_port_gen2.sv
// Router input port: decodes packet headers, forwards packets cut-through to one of
// NUM_PORTS FIFOs with parity/length/address checking and saturating statistics.
module router_in_port_gen2 #(
    parameter int DATA_W    = 8,
    parameter int LEN_BITS  = 5,
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    router_in_port_gen2_if.slave bus,
    input  logic                 i_clr_errors,
    output logic                 o_busy,
    output logic                 o_err_addr,
    output logic                 o_err_parity,
    output logic                 o_err_len,
    output logic [CNT_W-1:0]     o_pkt_cnt,
    output logic [CNT_W-1:0]     o_drop_cnt
);
    localparam int AW = DATA_W - LEN_BITS;
    localparam logic [AW:0] NP = (AW+1)'(NUM_PORTS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FWD  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]           state;
    logic [LEN_BITS-1:0]  len_q;
    logic [LEN_BITS-1:0]  cnt_q;
    logic [AW-1:0]        addr_q;
    logic [DATA_W-1:0]    xor_q;

    logic [NUM_PORTS-1:0] wr_en_p1;
    logic [DATA_W-1:0]    data_p1;
    logic                 last_p1;
    logic                 err_p1;

    logic [AW-1:0]        hdr_addr;
    logic [LEN_BITS-1:0]  hdr_len;
    logic                 hdr_legal;
    logic                 par_bad;
    logic                 xfer;

    function automatic logic afull_at(input logic [NUM_PORTS-1:0] af, input logic [AW-1:0] a);
        afull_at = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++)
            if (a == AW'(k)) afull_at = af[k];
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_sel(input logic [AW-1:0] a);
        port_sel = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            if (a == AW'(k)) port_sel[k] = 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + 1'b1;
    endfunction

    assign hdr_addr  = bus.data[AW-1:0];
    assign hdr_len   = bus.data[DATA_W-1:AW];
    assign hdr_legal = ({1'b0, hdr_addr} < NP);
    assign par_bad   = (bus.data != xor_q);
    assign xfer      = bus.valid & bus.ready;
    assign o_busy    = (state != S_IDLE);

    // Illegal headers and dropped bytes are always taken so the link never stalls on them.
    always_comb begin
        bus.ready = 1'b1;
        case (state)
            S_IDLE:  if (hdr_legal) bus.ready = ~afull_at(bus.fifo_afull, hdr_addr);
            S_FWD:   bus.ready = ~afull_at(bus.fifo_afull, addr_q);
            default: bus.ready = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            xor_q        <= '0;
            wr_en_p1     <= '0;
            data_p1      <= '0;
            last_p1      <= 1'b0;
            err_p1       <= 1'b0;
            o_err_addr   <= 1'b0;
            o_err_parity <= 1'b0;
            o_err_len    <= 1'b0;
            o_pkt_cnt    <= '0;
            o_drop_cnt   <= '0;
        end else begin
            wr_en_p1 <= '0;
            last_p1  <= 1'b0;
            err_p1   <= 1'b0;
            // Clear first so a set in the same cycle wins.
            if (i_clr_errors) begin
                o_err_addr   <= 1'b0;
                o_err_parity <= 1'b0;
                o_err_len    <= 1'b0;
            end
            if (xfer) begin
                case (state)
                    S_IDLE: begin
                        len_q  <= hdr_len;
                        addr_q <= hdr_addr;
                        xor_q  <= bus.data;
                        cnt_q  <= '0;
                        if (hdr_legal) begin
                            wr_en_p1 <= port_sel(hdr_addr);
                            data_p1  <= bus.data;
                            if (bus.last) begin
                                last_p1   <= 1'b1;
                                err_p1    <= 1'b1;
                                o_err_len <= 1'b1;
                                o_pkt_cnt <= sat_inc(o_pkt_cnt);
                            end else begin
                                state <= S_FWD;
                            end
                        end else begin
                            o_err_addr <= 1'b1;
                            o_drop_cnt <= sat_inc(o_drop_cnt);
                            if (bus.last) o_err_len <= 1'b1;
                            else          state     <= S_DROP;
                        end
                    end
                    S_FWD: begin
                        wr_en_p1 <= port_sel(addr_q);
                        data_p1  <= bus.data;
                        cnt_q    <= cnt_q + 1'b1;
                        xor_q    <= xor_q ^ bus.data;
                        if (cnt_q == len_q) begin
                            // Parity byte; a missing i_last means the rest of the frame is discarded.
                            last_p1   <= 1'b1;
                            err_p1    <= par_bad | ~bus.last;
                            o_pkt_cnt <= sat_inc(o_pkt_cnt);
                            if (par_bad) o_err_parity <= 1'b1;
                            if (bus.last) begin
                                state <= S_IDLE;
                            end else begin
                                o_err_len <= 1'b1;
                                state     <= S_DROP;
                            end
                        end else if (bus.last) begin
                            last_p1   <= 1'b1;
                            err_p1    <= 1'b1;
                            o_err_len <= 1'b1;
                            o_pkt_cnt <= sat_inc(o_pkt_cnt);
                            state     <= S_IDLE;
                        end
                    end
                    default: if (bus.last) state <= S_IDLE;
                endcase
            end
        end
    end

    // Output stage: registered FIFO write, one cycle after acceptance.
    assign bus.fifo_wr_en = wr_en_p1;
    assign bus.fifo_data  = data_p1;
    assign bus.fifo_last  = last_p1;
    assign bus.fifo_err   = err_p1;
endmodule

// File: tb/tb_router_in_port_gen2.sv
// Bench for router_in_port_gen2: directed scenarios plus random packets against a packet-level model.
module tb_router_in_port_gen2;
    localparam int DATA_W    = 8;
    localparam int LEN_BITS  = 5;
    localparam int NUM_PORTS = 4;
    localparam int CNT_W     = 4;
    localparam int AW        = DATA_W - LEN_BITS;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             busy;
    logic             e_addr, e_par, e_len;
    logic [CNT_W-1:0] pkt_cnt, drop_cnt;

    router_in_port_gen2_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) bus ();

    router_in_port_gen2 #(
        .DATA_W(DATA_W), .LEN_BITS(LEN_BITS), .NUM_PORTS(NUM_PORTS), .CNT_W(CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .i_clr_errors (clr),
        .o_busy       (busy),
        .o_err_addr   (e_addr),
        .o_err_parity (e_par),
        .o_err_len    (e_len),
        .o_pkt_cnt    (pkt_cnt),
        .o_drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int m_pkt, m_drop;
    bit m_ea, m_ep, m_el;

    logic [7:0] pb[$];
    bit         pl[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : CNT_MAX;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "/busy"},     32'(busy),     32'd0);
        chk({tag, "/err_addr"}, 32'(e_addr),   32'(m_ea));
        chk({tag, "/err_par"},  32'(e_par),    32'(m_ep));
        chk({tag, "/err_len"},  32'(e_len),    32'(m_el));
        chk({tag, "/pkt_cnt"},  32'(pkt_cnt),  32'(m_pkt));
        chk({tag, "/drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    // Offer one byte until accepted; check ready each cycle and the write one cycle after acceptance.
    task automatic drive_byte(input logic [7:0] d, input bit l, input bit ew, input bit el,
                              input bit ee, input bit r1, input logic [AW-1:0] a,
                              input bit rnd, input int hold, input string tag);
        bit done, xfer, er;
        int guard, h;
        logic [NUM_PORTS-1:0] exp_wr;
        done = 0; guard = 0; h = hold;
        while (!done && guard < 200) begin
            @(negedge clk);
            if (rnd) begin
                bus.fifo_afull = NUM_PORTS'($urandom) & NUM_PORTS'($urandom);
                bus.valid      = ($urandom_range(0, 3) != 0);
            end else begin
                bus.fifo_afull = '0;
                if (h > 0 && !r1) bus.fifo_afull[a] = 1'b1;
                bus.valid = 1'b1;
            end
            h--;
            bus.data = d;
            bus.last = l;
            #2;
            er = r1 ? 1'b1 : !bus.fifo_afull[a];
            chk({tag, "/ready"}, 32'(bus.ready), 32'(er));
            xfer = bus.valid && bus.ready;
            @(posedge clk);
            #1;
            exp_wr = (xfer && ew) ? (NUM_PORTS'(1) << a) : '0;
            chk({tag, "/wr_en"}, 32'(bus.fifo_wr_en), 32'(exp_wr));
            if (xfer && ew) begin
                chk({tag, "/data"}, 32'(bus.fifo_data), 32'(d));
                chk({tag, "/last"}, 32'(bus.fifo_last), 32'(el));
                chk({tag, "/err"},  32'(bus.fifo_err),  32'(ee));
            end
            done = xfer;
            guard++;
        end
        if (!done) chk({tag, "/accept_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic end_pkt(input string tag);
        @(negedge clk);
        bus.valid = 1'b0;
        bus.last = 1'b0;
        bus.fifo_afull = '0;
        clr = 1'b0;
        #1;
        check_status(tag);
    endtask

    // Packet-level model: header, len payload bytes, then parity = XOR of header and payload.
    task automatic run_pkt(input logic [7:0] b[$], input bit l[$], input bit rnd,
                           input int hold_at, input int hold_n, input string tag);
        logic [AW-1:0] a;
        logic [7:0]    x;
        int  len;
        bit  legal, dropping, ew, el, ee, r1;
        a = b[0][AW-1:0];
        len = int'(b[0][DATA_W-1:AW]);
        legal = (int'(a) < NUM_PORTS);
        x = 8'h00;
        dropping = !legal;
        if (!legal) begin
            m_ea = 1; m_drop = sat(m_drop);
            if (l[0]) m_el = 1;
        end
        for (int i = 0; i < b.size(); i++) begin
            ew = !dropping; el = 0; ee = 0; r1 = dropping;
            if (!dropping) begin
                if (i == len + 1) begin
                    el = 1;
                    ee = (b[i] != x) || !l[i];
                    if (b[i] != x) m_ep = 1;
                    if (!l[i]) m_el = 1;
                    m_pkt = sat(m_pkt);
                    dropping = !l[i];
                end else begin
                    x ^= b[i];
                    if (l[i]) begin
                        el = 1; ee = 1; m_el = 1; m_pkt = sat(m_pkt);
                    end
                end
            end
            drive_byte(b[i], l[i], ew, el, ee, r1, a, rnd, (i == hold_at) ? hold_n : 0, tag);
        end
        end_pkt(tag);
    endtask

    task automatic clear_flags(input string tag);
        @(negedge clk);
        clr = 1'b1;
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        m_ea = 0; m_ep = 0; m_el = 0;
        chk({tag, "/err_addr"}, 32'(e_addr), 32'd0);
        chk({tag, "/err_par"},  32'(e_par),  32'd0);
        chk({tag, "/err_len"},  32'(e_len),  32'd0);
    endtask

    task automatic rand_pkt(input int n);
        logic [7:0] b[$];
        bit l[$];
        logic [AW-1:0] a;
        logic [7:0] x, p;
        int kind, len, e;
        kind = $urandom_range(0, 6);
        len = $urandom_range(0, 6);
        if (kind == 5) len = (1 << LEN_BITS) - 1;
        if (kind == 3 && len == 0) len = 1;
        a = (kind == 2) ? AW'($urandom_range(NUM_PORTS, (1 << AW) - 1))
                        : AW'($urandom_range(0, NUM_PORTS - 1));
        x = {LEN_BITS'(len), a};
        b.push_back(x); l.push_back(1'b0);
        if (kind == 6) begin
            l[0] = 1'b1;
        end else begin
            for (int i = 0; i < len; i++) begin
                p = 8'($urandom);
                b.push_back(p); l.push_back(1'b0);
                x ^= p;
            end
            case (kind)
                1: begin b.push_back(x ^ (8'h01 << $urandom_range(0, 7))); l.push_back(1'b1); end
                3: begin
                    e = $urandom_range(1, len);
                    while (b.size() > e + 1) begin void'(b.pop_back()); void'(l.pop_back()); end
                    l[e] = 1'b1;
                end
                4: begin
                    b.push_back(x); l.push_back(1'b0);
                    for (int i = $urandom_range(1, 3); i > 0; i--) begin
                        b.push_back(8'($urandom)); l.push_back(i == 1);
                    end
                end
                default: begin b.push_back(x); l.push_back(1'b1); end
            endcase
        end
        run_pkt(b, l, 1'b1, -1, 0, $sformatf("rnd%0d_k%0d", n, kind));
        if ($urandom_range(0, 4) == 0) clear_flags($sformatf("rnd%0d_clr", n));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        bus.valid = 1'b0; bus.data = '0; bus.last = 1'b0; bus.fifo_afull = '0;
        m_pkt = 0; m_drop = 0; m_ea = 0; m_ep = 0; m_el = 0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        chk("reset/wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("reset/data",  32'(bus.fifo_data),  32'd0);
        chk("reset/last",  32'(bus.fifo_last),  32'd0);
        chk("reset/err",   32'(bus.fifo_err),   32'd0);
        chk("reset/ready", 32'(bus.ready),      32'd1);
        @(negedge clk);
        rst = 1'b0;

        pb = '{8'h11, 8'hA5, 8'h3C, 8'h88}; pl = '{0, 0, 0, 1};
        run_pkt(pb, pl, 1'b0, -1, 0, "t1_good");

        pb = '{8'h11, 8'hA5, 8'h3C, 8'h89}; pl = '{0, 0, 0, 1};
        run_pkt(pb, pl, 1'b0, -1, 0, "t2_parity");
        clear_flags("t2_clr");

        pb = '{8'h0D, 8'h55, 8'h58}; pl = '{0, 0, 1};
        run_pkt(pb, pl, 1'b0, -1, 0, "t3_badaddr");

        pb = '{8'h11, 8'hA5}; pl = '{0, 1};
        run_pkt(pb, pl, 1'b0, -1, 0, "t4_early");
        pb = '{8'h11, 8'hA5, 8'h3C, 8'h88}; pl = '{0, 0, 0, 1};
        run_pkt(pb, pl, 1'b0, -1, 0, "t4_next");

        run_pkt(pb, pl, 1'b0, 1, 3, "t5_afull");

        pb = '{8'h00, 8'h00}; pl = '{0, 1};
        run_pkt(pb, pl, 1'b0, -1, 0, "t6_zero");

        // Set wins over a clear held through the same cycle.
        @(negedge clk);
        clr = 1'b1;
        m_ea = 0; m_ep = 0; m_el = 0;
        pb = '{8'h07}; pl = '{1};
        run_pkt(pb, pl, 1'b0, -1, 0, "setclr");

        for (int i = 0; i < 2 * CNT_MAX; i++) begin
            pb = '{8'h06}; pl = '{1};
            run_pkt(pb, pl, 1'b1, -1, 0, $sformatf("dropsat%0d", i));
        end

        for (int i = 0; i < 60; i++) rand_pkt(i);

        // Reset in the middle of a forwarded packet.
        drive_byte(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 0, "t6_rst_hdr");
        drive_byte(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 0, "t6_rst_pay");
        chk("t6_rst/busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        bus.valid = 1'b0;
        bus.last = 1'b0;
        @(posedge clk);
        #1;
        m_pkt = 0; m_drop = 0; m_ea = 0; m_ep = 0; m_el = 0;
        check_status("t6_rst");
        chk("t6_rst/wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("t6_rst/data",  32'(bus.fifo_data),  32'd0);
        chk("t6_rst/last",  32'(bus.fifo_last),  32'd0);
        chk("t6_rst/err",   32'(bus.fifo_err),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        pb = '{8'h11, 8'hA5, 8'h3C, 8'h88}; pl = '{0, 0, 0, 1};
        run_pkt(pb, pl, 1'b1, -1, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
